// File: rtl/instruction_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage and its
// fetch-to-decode pipeline register.
package instruction_fetch_unit_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] INST_NOP         = 32'h0000_0013;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
    logic            isBranchTakenPredicted;
    logic            isNextPcPredicted;
    logic [XLEN-1:0] predictedNextPC;
  } FetchStagePipeReg;

  typedef enum logic [1:0] {
    FETCH,
    WAIT,
    DISCARD
  } FetchState;

  // Bubble presented to decode when nothing real is available.
  function automatic FetchStagePipeReg nop_bundle();
    FetchStagePipeReg b;
    b      = '0;
    b.inst = INST_NOP;
    return b;
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_queue.sv
// Small synchronous FIFO of fetched instructions with flush; state updates
// on the falling clock edge to match the fetch pipeline.
module fetch_queue
  import instruction_fetch_unit_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  FetchStagePipeReg       push_data_i,
  input  logic                   pop_i,
  input  logic                   flush_i,
  output FetchStagePipeReg       head_c,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   empty_c,
  output logic                   full_c
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  FetchStagePipeReg mem_q [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok, pop_ok;

  assign empty_c = (count_q == '0);
  assign full_c  = (count_q == CW'(DEPTH));
  assign head_c  = mem_q[head_q];
  assign count_o = count_q;

  // A flush wins over any push or pop on the same edge.
  assign push_ok = push_i && !flush_i && (!full_c || pop_i);
  assign pop_ok  = pop_i && !flush_i && !empty_c;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push_ok) tail_d = tail_q + PW'(1);
      if (pop_ok)  head_d = head_q + PW'(1);
      count_d = count_q + CW'(push_ok) - CW'(pop_ok);
    end
  end

  always_ff @(negedge clk) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(negedge clk) begin
    if (push_ok) mem_q[tail_q] <= push_data_i;
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, keeps one instruction-memory request in flight,
// buffers responses and drives the fetch-to-decode pipeline register.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter int unsigned QUEUE_DEPTH = 4,
  parameter logic [31:0] RESET_PC    = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imemReq,
  output logic [31:0] imemAddr,
  input  logic        imemReady,
  input  logic        imemRespValid,
  input  logic [31:0] imemRespData,
  input  logic        bpTaken,
  input  logic        bpTargetValid,
  input  logic [31:0] bpTarget,
  input  logic        stall,
  input  logic        redirectValid,
  input  logic [31:0] redirectPc,
  output logic        outValid,
  output logic [31:0] outPc,
  output logic [31:0] outInst,
  output logic        outIsBranchTakenPredicted,
  output logic        outIsNextPcPredicted,
  output logic [31:0] outPredictedNextPC
);

  localparam int unsigned CW = $clog2(QUEUE_DEPTH) + 1;

  FetchState        state_q, state_d;
  logic [31:0]      fetch_pc_q, fetch_pc_d;
  FetchStagePipeReg pend_q, pend_d;
  FetchStagePipeReg out_q, out_d;
  logic             out_valid_q, out_valid_d;

  FetchStagePipeReg q_head, push_data_c;
  logic [CW-1:0]    q_count;
  logic             q_empty, q_full;
  logic             push_c, pop_c, flush_c, accept_c, next_pc_pred_c;

  // Counting only buffered entries reserves a slot for the in-flight request.
  assign imemReq        = rst && (state_q == FETCH) && (q_count < CW'(QUEUE_DEPTH));
  assign imemAddr       = fetch_pc_q;
  assign accept_c       = imemReq && imemReady;
  assign next_pc_pred_c = bpTaken && bpTargetValid;
  assign flush_c        = redirectValid;

  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    pend_d      = pend_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    push_c      = 1'b0;
    pop_c       = 1'b0;
    push_data_c      = pend_q;
    push_data_c.inst = imemRespData;

    case (state_q)
      FETCH: begin
        if (accept_c) begin
          pend_d.pc                     = fetch_pc_q;
          pend_d.inst                   = '0;
          pend_d.isBranchTakenPredicted = bpTaken;
          pend_d.isNextPcPredicted      = next_pc_pred_c;
          pend_d.predictedNextPC        = next_pc_pred_c ? bpTarget : fetch_pc_q + 32'd4;
          fetch_pc_d                    = pend_d.predictedNextPC;
          state_d                       = redirectValid ? DISCARD : WAIT;
        end
      end
      WAIT: begin
        if (imemRespValid) begin
          state_d = FETCH;
          push_c  = !redirectValid && !q_full;
        end else if (redirectValid) begin
          state_d = DISCARD;
        end
      end
      DISCARD: begin
        if (imemRespValid) state_d = FETCH;
      end
      default: state_d = FETCH;
    endcase

    if (redirectValid) fetch_pc_d = redirectPc;

    // Pipeline register: redirect > stall > dequeue > bubble.
    if (redirectValid) begin
      out_d       = nop_bundle();
      out_valid_d = 1'b0;
    end else if (!stall) begin
      if (!q_empty) begin
        pop_c       = 1'b1;
        out_d       = q_head;
        out_valid_d = 1'b1;
      end else begin
        out_d       = nop_bundle();
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(negedge clk) begin
    if (!rst) begin
      state_q     <= FETCH;
      fetch_pc_q  <= RESET_PC;
      pend_q      <= '0;
      out_q       <= nop_bundle();
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      pend_q      <= pend_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  fetch_queue #(
    .DEPTH(QUEUE_DEPTH)
  ) u_fetch_queue (
    .clk        (clk),
    .rst        (rst),
    .push_i     (push_c),
    .push_data_i(push_data_c),
    .pop_i      (pop_c),
    .flush_i    (flush_c),
    .head_c     (q_head),
    .count_o    (q_count),
    .empty_c    (q_empty),
    .full_c     (q_full)
  );

  assign outValid                  = out_valid_q;
  assign outPc                     = out_q.pc;
  assign outInst                   = out_q.inst;
  assign outIsBranchTakenPredicted = out_q.isBranchTakenPredicted;
  assign outIsNextPcPredicted      = out_q.isNextPcPredicted;
  assign outPredictedNextPC        = out_q.predictedNextPC;

endmodule
